// File: rtl/sw_debouncer_pkg.sv
// rtl/sw_debouncer_pkg.sv - shared types and constants for the switch debouncer
//
// Purpose : bank FSM state encoding, default debounce length and the
//           released-switch reset value shared by sw_debounce_bank and
//           sw_debouncer.
// Ports   : none (package).

package sw_debouncer_pkg;

  // 20 ms of stable input at 24 MHz.
  localparam int DEBOUNCE_CNT_DEFAULT = 480000;

  // Switches are active-low, so "all released" is all ones.
  localparam logic [3:0] SW_RELEASED = 4'hF;

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } bank_state_e;

endpackage

// File: rtl/sw_debounce_bank.sv
// rtl/sw_debounce_bank.sv - one 4-bit switch bank: synchronizer, settle FSM, counter
//
// Purpose : synchronizes a raw 4-bit active-low switch bank into clk and
//           accepts a new value only after it has been seen unchanged, as a
//           whole vector, for DEBOUNCE_CNT consecutive cycles.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           sw_raw  - raw switch bank, asynchronous to clk
//           sw_db   - debounced switch bank (same polarity as sw_raw)
//           updated - high in the cycle whose closing edge loads a new sw_db

module sw_debounce_bank
  import sw_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_db,
  output logic       updated
);

  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       sync_q1;
  logic [3:0]       sync_q2;
  bank_state_e      state_q;
  bank_state_e      state_d;
  logic [3:0]       cand_q;
  logic [3:0]       cand_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       db_q;
  logic [3:0]       db_d;

  // Two-flop synchronizer; nothing downstream looks at sw_raw directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= SW_RELEASED;
      sync_q2 <= SW_RELEASED;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  // The candidate is, by construction, always different from db_q while
  // SETTLING, so the three SETTLING branches below never overlap.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    updated = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_q2 != db_q) begin
          cand_d  = sync_q2;
          cnt_d   = '0;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (sync_q2 == db_q) begin
          // Bounced back to the accepted value: drop the candidate quietly.
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (sync_q2 != cand_q) begin
          // Moved to yet another value: restart the settle window on it.
          cand_d = sync_q2;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          db_d    = cand_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
          updated = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      cand_q  <= SW_RELEASED;
      cnt_q   <= '0;
      db_q    <= SW_RELEASED;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - debouncer for the onboard and breadboard DIP switch banks
//
// Purpose : debounces two independent 4-bit active-low switch banks and
//           flags, with a single registered strobe, any cycle in which
//           either bank's debounced value changed. Outputs drive the adder's
//           switch inputs directly, keeping the active-low polarity.
// Ports   : clk           - system clock
//           reset_n       - asynchronous active-low reset
//           onboard_sw    - raw onboard DIP switches (active-low, async)
//           bboard_sw     - raw breadboard DIP switches (active-low, async)
//           onboard_sw_db - debounced onboard switches (active-low)
//           bboard_sw_db  - debounced breadboard switches (active-low)
//           sw_changed    - one-cycle strobe, high while a freshly loaded
//                           debounced value is first visible on either bank

module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] onboard_sw,
  input  logic [3:0] bboard_sw,
  output logic [3:0] onboard_sw_db,
  output logic [3:0] bboard_sw_db,
  output logic       sw_changed
);

  logic onboard_upd;
  logic bboard_upd;

  sw_debounce_bank #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_onboard (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_raw  (onboard_sw),
    .sw_db   (onboard_sw_db),
    .updated (onboard_upd)
  );

  sw_debounce_bank #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_bboard (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_raw  (bboard_sw),
    .sw_db   (bboard_sw_db),
    .updated (bboard_upd)
  );

  // Registered on the same edge that loads the debounced value, so the
  // strobe lines up with the first cycle the new value is visible, and
  // simultaneous bank updates merge into one pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= onboard_upd | bboard_upd;
    end
  end

endmodule
